serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, diff = a - b - bin, one bit per clock
//               LSB first, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int                c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_opa_q,   w_opa_d;
    logic [WIDTH-1:0]   r_opb_q,   w_opb_d;
    logic               r_br_q,    w_br_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0]   r_res_q,   w_res_d;
    logic [WIDTH-1:0]   r_diff_q,  w_diff_d;
    logic               r_bout_q,  w_bout_d;

    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_dbit;
    logic               w_br_nxt;
    logic [WIDTH-1:0]   w_res_sh;

    // One full-subtractor slice on the current LSBs of the operand shifters
    assign w_bit_a  = r_opa_q[0];
    assign w_bit_b  = r_opb_q[0];
    assign w_dbit   = w_bit_a ^ w_bit_b ^ r_br_q;
    assign w_br_nxt = (~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_br_q);

    always_comb begin
        w_res_sh            = r_res_q >> 1;
        w_res_sh[WIDTH-1]   = w_dbit;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_opa_d   = r_opa_q;
        w_opb_d   = r_opb_q;
        w_br_d    = r_br_q;
        w_cnt_d   = r_cnt_q;
        w_res_d   = r_res_q;
        w_diff_d  = r_diff_q;
        w_bout_d  = r_bout_q;

        if (r_state_q == S_RUN) begin
            w_opa_d = r_opa_q >> 1;
            w_opb_d = r_opb_q >> 1;
            w_br_d  = w_br_nxt;
            w_res_d = w_res_sh;
            w_cnt_d = r_cnt_q + c_cnt_one;
            if (r_cnt_q == c_last_cnt) begin
                w_state_d = S_DONE;
                w_diff_d  = w_res_sh;
                w_bout_d  = w_br_nxt;
            end
        end else if (start) begin
            // IDLE or DONE: a new request is accepted, DONE gives back-to-back
            w_state_d = S_RUN;
            w_opa_d   = a;
            w_opb_d   = b;
            w_br_d    = bin;
            w_cnt_d   = '0;
            w_res_d   = '0;
        end else begin
            w_state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_opa_q   <= '0;
            r_opb_q   <= '0;
            r_br_q    <= 1'b0;
            r_cnt_q   <= '0;
            r_res_q   <= '0;
            r_diff_q  <= '0;
            r_bout_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_opa_q   <= w_opa_d;
            r_opb_q   <= w_opb_d;
            r_br_q    <= w_br_d;
            r_cnt_q   <= w_cnt_d;
            r_res_q   <= w_res_d;
            r_diff_q  <= w_diff_d;
            r_bout_q  <= w_bout_d;
        end
    end

    assign busy = (r_state_q == S_RUN);
    assign done = (r_state_q == S_DONE);
    assign diff = r_diff_q;
    assign bout = r_bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor at WIDTH 8 and WIDTH 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: subtraction as addition of the complements
    function automatic logic [8:0] gold8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        logic [8:0] s;
        s = {1'b0, ia} + {1'b0, ~ib} + {8'd0, ~ibin};
        return {~s[8], s[7:0]};
    endfunction

    function automatic logic [1:0] gold1(input logic ia, input logic ib, input logic ibin);
        logic [1:0] s;
        s = {1'b0, ia} + {1'b0, ~ib} + {1'b0, ~ibin};
        return {~s[1], s[0]};
    endfunction

    // Called on a negedge; returns at the negedge of cycle E+1
    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        q8.push_back(gold8(ia, ib, ibin));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b1; a8 = 8'h44; b8 = 8'h11; bin8 = 1'b0;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, bout8, diff8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b bout=%b diff=%h want all zero", busy8, done8, bout8, diff8);
        end
        checks++;
        if ({busy1, done1, bout1, diff1} !== 4'd0) begin
            errors++;
            $display("FAIL reset1 got busy=%b done=%b bout=%b diff=%h want all zero", busy1, done1, bout1, diff1);
        end
        reset = 1'b0; start8 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins got busy8=%b busy1=%b want 0 0", busy8, busy1);
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp;
        issue8(8'h05, 8'h03, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0 || diff8 !== 8'h00) begin
                errors++;
                $display("FAIL basic_run k=%0d got busy=%b done=%b diff=%h want 1 0 00", k, busy8, done8, diff8);
            end
            @(negedge clk);
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_timing got done=%b busy=%b want 1 0", done8, busy8);
        end
        exp = q8.pop_front();
        checks++;
        if ({bout8, diff8} !== exp || exp !== 9'h002) begin
            errors++;
            $display("FAIL basic_result got %h want %h", {bout8, diff8}, 9'h002);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width got done=%b want 0", done8);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ta[2];
        logic [7:0] tb[2];
        logic       tbin[2];
        logic [8:0] exp;
        int         n;
        ta = '{8'h00, 8'h80}; tb = '{8'h01, 8'h7F}; tbin = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            issue8(ta[i], tb[i], tbin[i]);
            n = 1;
            while (!done8 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (done8 !== 1'b1 || n != 9) begin
                errors++;
                $display("FAIL wrap_timing op=%0d got done=%b at cycle %0d want done=1 at 9", i, done8, n);
            end
            exp = q8.pop_front();
            checks++;
            if ({bout8, diff8} !== exp) begin
                errors++;
                $display("FAIL wrap_result op=%0d got %h want %h", i, {bout8, diff8}, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        logic [8:0] exp;
        int         ndone;
        int         kdone;
        ndone = 0; kdone = 0;
        issue8(8'h12, 8'h34, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (done8 === 1'b1) begin
                ndone++;
                kdone = k;
                exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
                checks++;
                if ({bout8, diff8} !== exp) begin
                    errors++;
                    $display("FAIL ignored_result got %h want %h", {bout8, diff8}, exp);
                end
            end
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
            end
            if (k == 4) start8 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ndone != 1 || kdone != 9) begin
            errors++;
            $display("FAIL ignored_done_count got %0d pulses last at %0d want 1 at 9", ndone, kdone);
        end
        checks++;
        if (busy8 !== 1'b0 || q8.size() != 0) begin
            errors++;
            $display("FAIL ignored_no_relaunch got busy=%b queued=%0d want 0 0", busy8, q8.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta[4];
        logic [7:0] tb[4];
        logic       tbin[4];
        logic [8:0] exp;
        int         n;
        ta = '{8'h3C, 8'h01, 8'hA5, 8'hF0}; tb = '{8'h0F, 8'h02, 8'h5A, 8'h0F};
        tbin = '{1'b0, 1'b1, 1'b1, 1'b0};
        a8 = ta[0]; b8 = tb[0]; bin8 = tbin[0]; start8 = 1'b1;
        q8.push_back(gold8(ta[0], tb[0], tbin[0]));
        for (int op = 0; op < 4; op++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 4) begin
                    a8 = 8'($random); b8 = 8'($random); bin8 = 1'($random);
                end
            end while (!done8 && n < 30);
            checks++;
            if (done8 !== 1'b1 || n != 9) begin
                errors++;
                $display("FAIL b2b_period op=%0d got done=%b after %0d cycles want 1 after 9", op, done8, n);
            end
            exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
            checks++;
            if ({bout8, diff8} !== exp) begin
                errors++;
                $display("FAIL b2b_result op=%0d got %h want %h", op, {bout8, diff8}, exp);
            end
            if (op < 3) begin
                a8 = ta[op+1]; b8 = tb[op+1]; bin8 = tbin[op+1];
                q8.push_back(gold8(ta[op+1], tb[op+1], tbin[op+1]));
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        int         n;
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy8, done8, bout8, diff8} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_clear got busy=%b done=%b bout=%b diff=%h want all zero", busy8, done8, bout8, diff8);
        end
        reset = 1'b0;
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b1; start8 = 1'b1;
        q8.push_back(gold8(8'h10, 8'h01, 1'b1));
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart got busy=%b want 1", busy8);
        end
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done8 !== 1'b1 || n != 9) begin
            errors++;
            $display("FAIL midreset_timing got done=%b at cycle %0d want 1 at 9", done8, n);
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        checks++;
        if ({bout8, diff8} !== exp) begin
            errors++;
            $display("FAIL midreset_result got %h want %h", {bout8, diff8}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1'b1;
            q1.push_back(gold1(i[2], i[1], i[0]));
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_run i=%0d got busy=%b done=%b want 1 0", i, busy1, done1);
            end
            @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_done i=%0d got done=%b busy=%b want 1 0", i, done1, busy1);
            end
            exp = (q1.size() > 0) ? q1.pop_front() : 2'b11;
            checks++;
            if ({bout1, diff1} !== exp) begin
                errors++;
                $display("FAIL w1_result i=%0d got %b want %b", i, {bout1, diff1}, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] exp8;
        logic [1:0] exp1;
        int         n;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($random); rb = 8'($random); rbin = 1'($random);
            a8 = ra; b8 = rb; bin8 = rbin; start8 = 1'b1;
            q8.push_back(gold8(ra, rb, rbin));
            @(negedge clk);
            start8 = 1'b0;
            n = 1;
            while (!done8 && n < 20) begin
                @(negedge clk);
                n++;
            end
            exp8 = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
            checks++;
            if (done8 !== 1'b1 || {bout8, diff8} !== exp8) begin
                errors++;
                $display("FAIL rand8 i=%0d a=%h b=%h bin=%b got done=%b res=%h want res=%h", i, ra, rb, rbin, done8, {bout8, diff8}, exp8);
            end else begin
                $display("Test Passed");
            end
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($random); rb = 8'($random); rbin = 1'($random);
            a1 = ra[0]; b1 = rb[0]; bin1 = rbin; start1 = 1'b1;
            q1.push_back(gold1(ra[0], rb[0], rbin));
            @(negedge clk);
            start1 = 1'b0;
            n = 1;
            while (!done1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            exp1 = (q1.size() > 0) ? q1.pop_front() : 2'b11;
            checks++;
            if (done1 !== 1'b1 || {bout1, diff1} !== exp1) begin
                errors++;
                $display("FAIL rand1 i=%0d a=%b b=%b bin=%b got done=%b res=%b want res=%b", i, ra[0], rb[0], rbin, done1, {bout1, diff1}, exp1);
            end else begin
                $display("Test Passed");
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
